rv32_muldiv_unit: RTL

//  Iterative RV32M execute unit; the consumer of the decoder's m_valid/m_op outputs.

---
 rtl/rv32_muldiv_unit_pkg.sv | 45 ++++
 rtl/rv32_muldiv_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rv32_muldiv_unit_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
//  XLEN        : architectural register width
//  m_op_e      : M-extension funct3 encoding
//  md_state_e  : execute unit FSM states
//  is_div / is_rem / op_signed_a / op_signed_b : operation decode helpers
package rv32_muldiv_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic is_div(input m_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input m_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_signed_a(input m_op_e op);
        return (op == M_MUL) || (op == M_MULH) || (op == M_MULHSU) ||
               (op == M_DIV) || (op == M_REM);
    endfunction

    function automatic logic op_signed_b(input m_op_e op);
        return (op == M_MUL) || (op == M_MULH) || (op == M_DIV) || (op == M_REM);
    endfunction

endpackage

// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle. Divide-by-zero and signed overflow finish early.
// Ports:
//  clk, rst_n    : clock, asynchronous active-low reset
//  start         : request, sampled only in IDLE
//  op            : M-extension funct3
//  rs1, rs2      : operands (multiplicand/dividend, multiplier/divisor)
//  busy          : iterating; core stalls on start|busy
//  done          : one-cycle pulse, result valid
//  result        : final value, held until the next completion
module rv32_muldiv_unit
    import rv32_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  m_op_e            op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = 2 * WIDTH;

    md_state_e        r_state;
    md_state_e        w_next;
    m_op_e            r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    // Operand decode at accept time
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [AW-1:0]    w_special_acc;

    always_comb begin
        w_sa       = op_signed_a(op) & rs1[WIDTH-1];
        w_sb       = op_signed_b(op) & rs2[WIDTH-1];
        w_abs_a    = w_sa ? (~rs1 + WIDTH'(1)) : rs1;
        w_abs_b    = w_sb ? (~rs2 + WIDTH'(1)) : rs2;
        w_div_zero = (rs2 == '0);
        w_ovf      = ((op == M_DIV) || (op == M_REM)) &&
                     (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
        w_special  = is_div(op) & (w_div_zero | w_ovf);
        // Acc holds {remainder, quotient}; overflow quotient equals rs1 itself
        w_special_acc = w_div_zero ? {rs1, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, rs1};
    end

    // One iteration of multiply and of restoring divide
    logic [AW-1:0]    w_mul_acc;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [AW-1:0]    w_div_acc;

    always_comb begin
        w_mul_acc = r_acc + (r_b[0] ? r_mcand : AW'(0));
        // Shifted remainder needs one extra bit when the divisor exceeds 2^(W-1)
        w_rem_sh  = r_acc[AW-1:WIDTH-1];
        w_ge      = (w_rem_sh >= {1'b0, r_b});
        w_sub     = w_rem_sh[WIDTH-1:0] - r_b;
        w_div_acc = {(w_ge ? w_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
    end

    // Shared sign-fix negator and result select
    logic [WIDTH-1:0] w_sel;
    logic [AW-1:0]    w_fix_in;
    logic             w_neg_en;
    logic [AW-1:0]    w_fixed;
    logic [WIDTH-1:0] w_res_val;

    always_comb begin
        w_sel     = is_rem(r_op) ? r_acc[AW-1:WIDTH] : r_acc[WIDTH-1:0];
        w_fix_in  = is_div(r_op) ? {{WIDTH{1'b0}}, w_sel} : r_acc;
        w_neg_en  = is_rem(r_op) ? r_neg_r : r_neg_q;
        w_fixed   = w_neg_en ? (~w_fix_in + AW'(1)) : w_fix_in;
        w_res_val = (!is_div(r_op) && (r_op != M_MUL)) ? w_fixed[AW-1:WIDTH]
                                                       : w_fixed[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MD_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_IDLE: if (start) w_next = w_special ? MD_DONE : MD_BUSY;
            MD_BUSY: if (r_cnt == CW'(WIDTH - 1)) w_next = MD_DONE;
            MD_DONE: w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= M_MUL;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_busy <= (w_next == MD_BUSY);
            r_done <= (r_state == MD_DONE);
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        // Special results are already final: no sign fix
                        r_neg_q <= ~w_special & (w_sa ^ w_sb);
                        r_neg_r <= ~w_special & w_sa;
                        r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
                        r_b     <= w_abs_b;
                        r_cnt   <= '0;
                        if (w_special)   r_acc <= w_special_acc;
                        else if (is_div(op)) r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                        else             r_acc <= '0;
                    end
                end
                MD_BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (is_div(r_op)) begin
                        r_acc <= w_div_acc;
                    end else begin
                        r_acc   <= w_mul_acc;
                        r_mcand <= r_mcand << 1;
                        r_b     <= r_b >> 1;
                    end
                end
                MD_DONE: r_result <= w_res_val;
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
